// File: rtl/instruction_fetch_unit_if.sv
// Interface bundle for instruction_fetch_unit: redirect input, MMU fetch
// request/response channels and the decode-side output channel.
//   master : the fetch unit (drives requests, response ready, decode outputs)
//   slave  : the environment (execute redirect, MMU, decode stage)
interface instruction_fetch_unit_if;
  logic        redirect_valid_in;
  logic [31:0] redirect_pc_in;

  logic        fetch_request_ready_in;
  logic        fetch_request_valid_out;
  logic [31:0] fetch_request_address_out;

  logic        fetch_response_ready_out;
  logic        fetch_response_valid_in;
  logic [31:0] fetch_response_data_in;

  logic        decode_ready_in;
  logic        decode_valid_out;
  logic [31:0] decode_instruction_out;
  logic [31:0] decode_pc_out;

  modport master (
    input  redirect_valid_in, redirect_pc_in,
    input  fetch_request_ready_in,
    output fetch_request_valid_out, fetch_request_address_out,
    output fetch_response_ready_out,
    input  fetch_response_valid_in, fetch_response_data_in,
    input  decode_ready_in,
    output decode_valid_out, decode_instruction_out, decode_pc_out
  );

  modport slave (
    output redirect_valid_in, redirect_pc_in,
    output fetch_request_ready_in,
    input  fetch_request_valid_out, fetch_request_address_out,
    input  fetch_response_ready_out,
    output fetch_response_valid_in, fetch_response_data_in,
    output decode_ready_in,
    input  decode_valid_out, decode_instruction_out, decode_pc_out
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage in front of the instruction MMU. Holds the PC, issues one
// word-aligned request per cycle, pairs in-order responses with their PC in a
// circular queue and presents {pc, instruction} to decode. A redirect flushes
// the queue and arranges for responses to stale in-flight requests to be
// dropped.
// Ports:
//   clk_in   : clock, rising edge
//   rst_in   : asynchronous active-low reset
//   fetch_if : instruction_fetch_unit_if.master (redirect, MMU request and
//              response channels, decode channel)
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  instruction_fetch_unit_if.master      fetch_if
);

  localparam int unsigned IDX_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam logic [31:0]    RESET_PC_ALIGNED = RESET_PC & ~32'h3;
  localparam logic [PTR_W:0] DEPTH_W          = (PTR_W + 1)'(QUEUE_DEPTH);

  logic [31:0]      fetch_pc_q,    fetch_pc_d;
  logic [PTR_W-1:0] head_q,        head_d;
  logic [PTR_W-1:0] fill_q,        fill_d;
  logic [PTR_W-1:0] alloc_q,       alloc_d;
  logic [PTR_W-1:0] drop_count_q,  drop_count_d;

  logic [31:0] pc_q    [QUEUE_DEPTH];
  logic [31:0] instr_q [QUEUE_DEPTH];

  logic [PTR_W:0] credit_used;
  logic           credit;
  logic           req_valid, dec_valid;
  logic           req_fire, resp_fire, dec_fire;
  logic           resp_keep;
  logic [PTR_W-1:0] alloc_next;

  // Slots owed to outstanding requests plus responses still to be discarded;
  // one bit wider than the pointers so the sum cannot wrap.
  assign credit_used = {1'b0, alloc_q - head_q} + {1'b0, drop_count_q};
  assign credit      = credit_used < DEPTH_W;

  // Valids are gated by reset so they drop as soon as reset is asserted.
  assign req_valid = rst_in && credit && !fetch_if.redirect_valid_in;
  assign dec_valid = rst_in && (head_q != fill_q) && !fetch_if.redirect_valid_in;

  assign req_fire  = req_valid && fetch_if.fetch_request_ready_in;
  assign resp_fire = rst_in && fetch_if.fetch_response_valid_in;
  assign dec_fire  = dec_valid && fetch_if.decode_ready_in;

  // Only responses to live requests are written; anything arriving while
  // drops are owed, or in a redirect cycle, is discarded.
  assign resp_keep = resp_fire && (drop_count_q == '0) && !fetch_if.redirect_valid_in;

  assign fetch_if.fetch_request_valid_out   = req_valid;
  assign fetch_if.fetch_request_address_out = fetch_pc_q;
  assign fetch_if.fetch_response_ready_out  = rst_in;
  assign fetch_if.decode_valid_out          = dec_valid;
  assign fetch_if.decode_pc_out             = rst_in ? pc_q[head_q[IDX_W-1:0]]    : '0;
  assign fetch_if.decode_instruction_out    = rst_in ? instr_q[head_q[IDX_W-1:0]] : '0;

  assign alloc_next = alloc_q + PTR_W'(req_fire);

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    head_d       = head_q;
    fill_d       = fill_q;
    alloc_d      = alloc_q;
    drop_count_d = drop_count_q;
    if (fetch_if.redirect_valid_in) begin
      // Everything in [fill, alloc) is still in flight and becomes a drop;
      // a response consumed this cycle settles one of those drops.
      fetch_pc_d   = fetch_if.redirect_pc_in & ~32'h3;
      head_d       = alloc_next;
      fill_d       = alloc_next;
      alloc_d      = alloc_next;
      drop_count_d = drop_count_q + (alloc_q - fill_q) + PTR_W'(req_fire)
                     - PTR_W'(resp_fire);
    end else begin
      if (req_fire) begin
        alloc_d    = alloc_q + 1'b1;
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (resp_fire) begin
        if (drop_count_q != '0) drop_count_d = drop_count_q - 1'b1;
        else                    fill_d       = fill_q + 1'b1;
      end
      if (dec_fire) head_d = head_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fetch_pc_q   <= RESET_PC_ALIGNED;
      head_q       <= '0;
      fill_q       <= '0;
      alloc_q      <= '0;
      drop_count_q <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      head_q       <= head_d;
      fill_q       <= fill_d;
      alloc_q      <= alloc_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Queue storage carries no reset; contents are only read between head and fill.
  always_ff @(posedge clk_in) begin
    if (req_fire)  pc_q[alloc_q[IDX_W-1:0]]   <= fetch_pc_q;
    if (resp_keep) instr_q[fill_q[IDX_W-1:0]] <= fetch_if.fetch_response_data_in;
  end

endmodule
